// File: rtl/bcd_div_ctrl_if.sv
// Handshake/config/status bundle between system control (master) and the BCD divide controller (slave).
interface bcd_div_ctrl_if;
  logic       cfg_valid;
  logic [7:0] cfg_tc;
  logic       cfg_oneshot;
  logic       cfg_ready;
  logic       cfg_err;
  logic       start;
  logic       stop;
  logic       Cin;
  logic [7:0] count;
  logic       tick;
  logic       busy;
  logic       done;

  modport master (
    output cfg_valid, cfg_tc, cfg_oneshot, start, stop, Cin,
    input  cfg_ready, cfg_err, count, tick, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_tc, cfg_oneshot, start, stop, Cin,
    output cfg_ready, cfg_err, count, tick, busy, done
  );
endinterface

// File: rtl/bcd_div_ctrl.sv
// Two-digit BCD divide counter controller: config handshake, start/stop, one-shot/continuous, terminal-count tick.
// Optional DIV_CTRL_TICK_CNT_EN adds a saturating 16-bit tick_total output.
module bcd_div_ctrl #(
  parameter logic [2:0] HI_MAX     = 3'd7,
  parameter logic [7:0] DEFAULT_TC = 8'h79
) (
  input  logic            clk,
  input  logic            Rst_n,
  bcd_div_ctrl_if.slave   bus
`ifdef DIV_CTRL_TICK_CNT_EN
  ,
  output logic [15:0]     tick_total
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] HI_LIM = {1'b0, HI_MAX};

  logic [1:0] state;
  logic [7:0] count;
  logic [7:0] tc;
  logic       oneshot;
  logic       tick;
  logic       done;
  logic       cfg_err;
  logic       cfg_legal;
  logic [3:0] units;
  logic [3:0] tens;

  assign units     = count[3:0];
  assign tens      = count[7:4];
  assign cfg_legal = (bus.cfg_tc[3:0] <= 4'd9) && (bus.cfg_tc[7:4] <= HI_LIM);

  assign bus.cfg_ready = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.count     = count;
  assign bus.tick      = tick;
  assign bus.done      = done;
  assign bus.cfg_err   = cfg_err;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      count   <= 8'h00;
      tc      <= DEFAULT_TC;
      oneshot <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      tick    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            if (cfg_legal) begin
              tc      <= bus.cfg_tc;
              oneshot <= bus.cfg_oneshot;
            end else begin
              cfg_err <= 1'b1;
            end
          end
          if (bus.start && !bus.stop) begin
            state <= RUN;
            count <= 8'h00;
          end
        end
        RUN: begin
          // stop has priority over a coincident terminal count
          if (bus.stop) begin
            state <= IDLE;
            count <= 8'h00;
          end else if (bus.Cin) begin
            if (count == tc) begin
              count <= 8'h00;
              tick  <= 1'b1;
              if (oneshot) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else if (units == 4'd9) begin
              count <= {((tens == HI_LIM) ? 4'd0 : tens + 4'd1), 4'd0};
            end else begin
              count <= {tens, units + 4'd1};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          count <= 8'h00;
        end
        default: begin
          state <= IDLE;
          count <= 8'h00;
        end
      endcase
    end
  end

`ifdef DIV_CTRL_TICK_CNT_EN
  // Counts at the edge that raises tick, so the total is current while tick is visible.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tick_total <= 16'h0000;
    end else if (state == IDLE && bus.cfg_valid && cfg_legal) begin
      tick_total <= 16'h0000;
    end else if (state == RUN && !bus.stop && bus.Cin && count == tc &&
                 tick_total != 16'hFFFF) begin
      tick_total <= tick_total + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_div_ctrl.sv
// Directed self-checking bench for bcd_div_ctrl (default HI_MAX=7, DEFAULT_TC=8'h79).
module tb_bcd_div_ctrl;
  logic clk = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   en;

  always #5 clk = ~clk;

  bcd_div_ctrl_if bus();
`ifdef DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_total;
`endif

  bcd_div_ctrl dut (
    .clk   (clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
`ifdef DIV_CTRL_TICK_CNT_EN
    ,
    .tick_total (tick_total)
`endif
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic cfg(input logic [7:0] tcv, input logic os);
    bus.cfg_valid   = 1'b1;
    bus.cfg_tc      = tcv;
    bus.cfg_oneshot = os;
    step();
    bus.cfg_valid   = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_tc = 8'h00; bus.cfg_oneshot = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.Cin = 1'b0;

    // Reset state
    #2;
    chk_w("rst_count", 16'(bus.count), 16'h00);
    chk_b("rst_busy", bus.busy, 1'b0);
    chk_b("rst_tick", bus.tick, 1'b0);
    chk_b("rst_done", bus.done, 1'b0);
    chk_b("rst_err", bus.cfg_err, 1'b0);
    chk_b("rst_ready", bus.cfg_ready, 1'b1);
    #20 Rst_n = 1'b1;
    step();

    // Default tc=79, continuous: tick every 80 enabled cycles
    go();
    chk_b("t1_busy", bus.busy, 1'b1);
    chk_w("t1_count0", 16'(bus.count), 16'h00);
    bus.Cin = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      step();
      chk_w("t1_count", 16'(bus.count), 16'(bcd(i % 80)));
      chk_b("t1_tick", bus.tick, (i % 80) == 0);
    end
    chk_b("t1_no_done", bus.done, 1'b0);
    bus.stop = 1'b1; step(); bus.stop = 1'b0; bus.Cin = 1'b0;
    chk_b("t1_stop_busy", bus.busy, 1'b0);
    chk_w("t1_stop_count", 16'(bus.count), 16'h00);

    // Illegal configs rejected, tc/oneshot retained
    cfg(8'h3A, 1'b1);
    chk_b("t3_err_3A", bus.cfg_err, 1'b1);
    step();
    chk_b("t3_err_clr", bus.cfg_err, 1'b0);
    cfg(8'h85, 1'b1);
    chk_b("t3_err_85", bus.cfg_err, 1'b1);
    step();
    chk_b("t3_err_clr2", bus.cfg_err, 1'b0);
    go();
    bus.Cin = 1'b1;
    repeat (79) step();
    chk_w("t3_count79", 16'(bus.count), 16'h79);
    chk_b("t3_no_tick79", bus.tick, 1'b0);
    step();
    chk_b("t3_tick", bus.tick, 1'b1);
    chk_b("t3_no_done", bus.done, 1'b0);
    chk_b("t3_busy", bus.busy, 1'b1);
    chk_w("t3_wrap", 16'(bus.count), 16'h00);
    bus.stop = 1'b1; bus.Cin = 1'b0; step(); bus.stop = 1'b0;

    // One-shot tc=09
    cfg(8'h09, 1'b1);
    chk_b("t2_no_err", bus.cfg_err, 1'b0);
    go();
    bus.Cin = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk_w("t2_count", 16'(bus.count), 16'(bcd(i)));
    end
    step();
    chk_b("t2_tick", bus.tick, 1'b1);
    chk_b("t2_done", bus.done, 1'b1);
    chk_b("t2_busy", bus.busy, 1'b0);
    chk_b("t2_ready_done", bus.cfg_ready, 1'b0);
    chk_w("t2_count_done", 16'(bus.count), 16'h00);
    step();
    chk_b("t2_done_clr", bus.done, 1'b0);
    chk_b("t2_tick_clr", bus.tick, 1'b0);
    chk_b("t2_ready", bus.cfg_ready, 1'b1);
    chk_w("t2_count_idle", 16'(bus.count), 16'h00);
    bus.Cin = 1'b0;

    // tc=05 continuous with gated Cin
    cfg(8'h05, 1'b0);
    go();
    en = 0;
    for (int k = 1; k <= 24; k++) begin
      bus.Cin = k[0];
      step();
      if (k[0]) en++;
      chk_w("t4_count", 16'(bus.count), 16'(bcd(en % 6)));
      chk_b("t4_tick", bus.tick, k[0] && (en % 6) == 0);
    end

    // stop coincident with terminal count: no tick
    bus.Cin = 1'b1;
    repeat (5) step();
    chk_w("t5_count05", 16'(bus.count), 16'h05);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0; bus.Cin = 1'b0;
    chk_b("t5_no_tick", bus.tick, 1'b0);
    chk_b("t5_busy", bus.busy, 1'b0);
    chk_w("t5_count", 16'(bus.count), 16'h00);
    chk_b("t5_ready", bus.cfg_ready, 1'b1);

    // start and stop together in IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_b("ss_busy", bus.busy, 1'b0);

    // Async reset mid-run at count 42
    cfg(8'h79, 1'b0);
    go();
    bus.Cin = 1'b1;
    repeat (42) step();
    chk_w("t6_count42", 16'(bus.count), 16'h42);
    #2 Rst_n = 1'b0;
    #1;
    chk_w("t6_rst_count", 16'(bus.count), 16'h00);
    chk_b("t6_rst_busy", bus.busy, 1'b0);
    bus.Cin = 1'b0;
    #10 Rst_n = 1'b1;
    step();

`ifdef DIV_CTRL_TICK_CNT_EN
    cfg(8'h00, 1'b0);
    chk_w("tt_clr0", tick_total, 16'h0000);
    go();
    bus.Cin = 1'b1;
    repeat (3) step();
    bus.Cin = 1'b0;
    chk_w("tt_three", tick_total, 16'h0003);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    cfg(8'h05, 1'b0);
    chk_w("tt_cfg_clr", tick_total, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
